// File: rtl/t1a_fs_pwm_pkg.sv
// Shared constants for the 50 MHz -> 1 MHz / 500 Hz divider and 500 Hz PWM block.
// Counter widths are derived from the divide ratios so the RTL follows any retuning.
package t1a_fs_pwm_pkg;

  localparam int CLK_HZ         = 50_000_000;
  localparam int DIV_1MHZ_HALF  = 25;
  localparam int DIV_500HZ_HALF = 50_000;
  localparam int PWM_PERIOD     = 100_000;
  localparam int PWM_STEP       = 5_000;

  localparam int CNT_1MHZ_W  = $clog2(DIV_1MHZ_HALF);
  localparam int CNT_500HZ_W = $clog2(DIV_500HZ_HALF);
  localparam int CNT_PWM_W   = $clog2(PWM_PERIOD);

  // A ratio of 1 still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_toggle.sv
// Registered 50 % square wave: toggles whenever the 0..HALF-1 counter is at 0,
// so the first edge after reset release drives the output high.
module clk_div_toggle
  import t1a_fs_pwm_pkg::*;
#(
  parameter int HALF = DIV_1MHZ_HALF
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  output logic clk_out
);

  localparam int W = cnt_w(HALF);

  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;

  always_comb begin
    cnt_d = (cnt_q == W'(HALF - 1)) ? '0 : cnt_q + W'(1);
    clk_d = (cnt_q == '0) ? ~clk_q : clk_q;
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign clk_out = clk_q;

endmodule

// File: rtl/t1a_fs_pwm_bdf.sv
// Frequency-scaling / PWM top: two toggle dividers plus a 2 ms PWM whose
// high time is pulse_width * 100 us, latched once per period.
module t1a_fs_pwm_bdf
  import t1a_fs_pwm_pkg::*;
#(
  parameter int HALF_1MHZ  = DIV_1MHZ_HALF,
  parameter int HALF_500HZ = DIV_500HZ_HALF,
  parameter int PERIOD     = PWM_PERIOD,
  parameter int STEP       = PWM_STEP
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic [3:0] pulse_width,
  output logic       clk_1MHz,
  output logic       clk_500Hz,
  output logic       pwm_signal
);

  localparam int PW = cnt_w(PERIOD);

  clk_div_toggle #(.HALF(HALF_1MHZ)) u_div_1mhz (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .clk_out   (clk_1MHz)
  );

  clk_div_toggle #(.HALF(HALF_500HZ)) u_div_500hz (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .clk_out   (clk_500Hz)
  );

  logic [PW-1:0] p_q, p_d;
  logic [PW-1:0] thresh;
  logic [3:0]    pw_q, pw_d, pw_eff;
  logic          pwm_q, pwm_d;

  // The live input is used only on the period-start edge, so a mid-period
  // change cannot alter the period already running.
  always_comb begin
    pw_eff = (p_q == '0) ? pulse_width : pw_q;
    pw_d   = pw_eff;
    thresh = PW'(pw_eff) * PW'(STEP);
    p_d    = (p_q == PW'(PERIOD - 1)) ? '0 : p_q + PW'(1);
    pwm_d  = (p_q < thresh);
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      p_q   <= '0;
      pw_q  <= '0;
      pwm_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      pw_q  <= pw_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_signal = pwm_q;

endmodule

// File: tb/tb_t1a_fs_pwm_bdf.sv
// Directed bench for t1a_fs_pwm_bdf with the divide ratios scaled down 100x
// (PWM period 1000 cycles, step 50, 500 Hz half-period 500, 1 MHz half-period 25).
module tb_t1a_fs_pwm_bdf;

  localparam int H1   = 25;
  localparam int H500 = 500;
  localparam int PER  = 1000;
  localparam int STEP = 50;

  logic       clk_50MHz = 1'b0;
  logic       rst_n     = 1'b0;
  logic [3:0] pulse_width = 4'd0;
  logic       clk_1MHz, clk_500Hz, pwm_signal;

  int checks = 0;
  int errors = 0;
  int g      = 0;

  always #10 clk_50MHz = ~clk_50MHz;

  t1a_fs_pwm_bdf #(
    .HALF_1MHZ  (H1),
    .HALF_500HZ (H500),
    .PERIOD     (PER),
    .STEP       (STEP)
  ) dut (
    .clk_50MHz   (clk_50MHz),
    .rst_n       (rst_n),
    .pulse_width (pulse_width),
    .clk_1MHz    (clk_1MHz),
    .clk_500Hz   (clk_500Hz),
    .pwm_signal  (pwm_signal)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One aligned PWM period. pw1 is applied before edge mid_at (-1: never).
  // g is the edge index since the last reset release.
  task automatic run_period(input string tag, input int pw0, input int pw1,
                            input int mid_at, input int exp_high);
    int pwm_bad = 0;
    int c1_bad  = 0;
    int c5_bad  = 0;
    int highs   = 0;
    pulse_width = pw0[3:0];
    for (int i = 0; i < PER; i++) begin
      if (i == mid_at) pulse_width = pw1[3:0];
      @(posedge clk_50MHz);
      #1;
      if (pwm_signal !== (i < exp_high)) pwm_bad++;
      if (pwm_signal === 1'b1) highs++;
      if (clk_1MHz !== (((g / H1) % 2) == 0)) c1_bad++;
      if (clk_500Hz !== (((g / H500) % 2) == 0)) c5_bad++;
      g++;
    end
    check({tag, "_pwm_high"}, highs, exp_high);
    check({tag, "_pwm_shape_bad"}, pwm_bad, 0);
    check({tag, "_clk1_bad"}, c1_bad, 0);
    check({tag, "_clk500_bad"}, c5_bad, 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    pulse_width = 4'd8;
    repeat (3) @(negedge clk_50MHz);
    check("rst_clk1", clk_1MHz, 0);
    check("rst_clk500", clk_500Hz, 0);
    check("rst_pwm", pwm_signal, 0);

    @(negedge clk_50MHz);
    rst_n = 1'b1;
    g     = 0;

    run_period("const8", 8, 8, -1, 8 * STEP);
    run_period("seq8", 8, 8, -1, 8 * STEP);
    run_period("seq11", 11, 11, -1, 11 * STEP);
    run_period("seq4a", 4, 4, -1, 4 * STEP);
    run_period("seq12", 12, 12, -1, 12 * STEP);
    run_period("seq4b", 4, 4, -1, 4 * STEP);
    run_period("seq5", 5, 5, -1, 5 * STEP);
    run_period("seq9", 9, 9, -1, 9 * STEP);
    run_period("seq13", 13, 13, -1, 13 * STEP);

    run_period("mid4to12", 4, 12, PER / 2, 4 * STEP);
    run_period("after12", 12, 12, -1, 12 * STEP);

    run_period("pw0", 0, 0, -1, 0);
    run_period("pw15", 15, 15, -1, 15 * STEP);

    pulse_width = 4'd15;
    repeat (300) @(posedge clk_50MHz);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_clk1", clk_1MHz, 0);
    check("midrst_clk500", clk_500Hz, 0);
    check("midrst_pwm", pwm_signal, 0);
    repeat (4) @(posedge clk_50MHz);
    #1;
    check("held_rst_pwm", pwm_signal, 0);

    @(negedge clk_50MHz);
    rst_n = 1'b1;
    g     = 0;
    run_period("restart8", 8, 8, -1, 8 * STEP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t1a_fs_pwm_bdf.md
# t1a_fs_pwm_bdf

Clock-generation and PWM block. It derives a 1 MHz square wave and a 500 Hz square wave from a 50 MHz system clock. It also produces a 500 Hz PWM signal whose duty cycle is set in 5 % steps by a 4-bit `pulse_width` input. It sits at the top of the frequency-scaling/PWM datapath and feeds downstream timing and actuator logic.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency (fixed; kept for documentation and derived constants).
- `DIV_1MHZ_HALF`, 25: input cycles per half-period of `clk_1MHz`.
- `DIV_500HZ_HALF`, 50_000: input cycles per half-period of `clk_500Hz`.
- `PWM_PERIOD`, 100_000: input cycles per PWM period (2 ms).
- `PWM_STEP`, 5_000: input cycles per `pulse_width` unit (100 µs).

Ports:
- `clk_50MHz`  in  1  system clock, 50 MHz; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pulse_width`  in  4  PWM high time in 100 µs units (0–15).
- `clk_1MHz`  out  1  registered 50 % square wave, 1 MHz.
- `clk_500Hz`  out  1  registered 50 % square wave, 500 Hz.
- `pwm_signal`  out  1  registered PWM output, 2 ms period.

## Operation
- All logic runs on `posedge clk_50MHz`.
- `rst_n` low (asynchronous) clears every counter and drives all three outputs to 0.
- Divider (1 MHz and 500 Hz, identical scheme, N = half-period):
  - Counter `c` runs 0..N-1 and wraps.
  - On each edge where `c == 0`, the output toggles.
  - The first edge after reset release therefore drives the output to 1.
- PWM:
  - Period counter `p` runs 0..PWM_PERIOD-1 and wraps.
  - At `p == 0`, `pulse_width` is latched into `pw_q`. The latched value governs the whole period.
  - On each edge, `pwm_signal <= (p < pw_eff*PWM_STEP)`, where `pw_eff` is the live `pulse_width` when `p == 0` and `pw_q` otherwise.
  - Changes to `pulse_width` mid-period take effect at the next period start.
  - `pulse_width = 0` keeps the output low for the whole period.
  - Maximum value 15 gives 75 % duty. Values never reach a 100 % duty.
- Counter widths: 5 bits (1 MHz), 16 bits (500 Hz), 17 bits (PWM). The comparison product `pw_eff*PWM_STEP` is 17 bits unsigned; there is no overflow at 15×5000 = 75 000.

## Timing
- Let edge 0 be the first rising clock edge after `rst_n` deasserts. At edge 0, `clk_1MHz`, `clk_500Hz` and `pwm_signal` (if `pulse_width ≠ 0`) all go high.
- `clk_1MHz` toggles at edges 0, 25, 50, …: high 500 ns, low 500 ns.
- `clk_500Hz` toggles at edges 0, 50 000, 100 000, …: high 1 ms, low 1 ms.
- `pwm_signal` rises at edges k·100 000 and falls at edge k·100 000 + pw·5 000.
- All outputs are register-driven with no combinational path from input to output. `pulse_width` is sampled only at period start.
- Reset asserted mid-operation: outputs go to 0 immediately and the phase restarts from edge 0 on release.

## Structure
- Package `t1a_fs_pwm_pkg`: the five constants above plus counter-width localparams computed with `$clog2`.
- Sub-module `clk_div_toggle`:
  - Parameter `HALF`.
  - Ports `clk_50MHz`, `rst_n`, `clk_out`.
  - Instantiated twice, once for each square-wave output.
- PWM counter and compare logic are inline in the top level.

## Test plan
- Reset, release, constant `pulse_width = 8` → `clk_1MHz` high 25 / low 25 cycles; `clk_500Hz` high 50 000 / low 50 000 cycles; `pwm_signal` high 40 000 / low 60 000 cycles per period, all rising at edge 0.
- Sequence 8, 11, 4, 12, 4, 5, 9, 13, each applied for exactly one 2 ms period aligned to period start → high time equals value×5 000 cycles in each period; zero mismatches against a cycle-accurate model.
- Change `pulse_width` from 4 to 12 at cycle 50 000 of a period → current period stays at 20 000 cycles high; the next period is 60 000 cycles high.
- `pulse_width = 0` → `pwm_signal` constantly 0. `pulse_width = 15` → 75 000 cycles high, 25 000 cycles low.
- Assert `rst_n` low at an arbitrary mid-period cycle → all outputs 0 in the same cycle. After release, the sequence restarts exactly as from edge 0.
